// File: rtl/cdb_broadcaster_if.sv
// Bus bundle between the adder result producers, the register status table and
// the CDB transmit block.
interface cdb_broadcaster_if #(
  parameter int unsigned DATA_W = 16
) ();
  logic              valid_add1;
  logic [DATA_W-1:0] result_add1;
  logic [2:0]        dest_add1;
  logic              ready_add1;
  logic              valid_add2;
  logic [DATA_W-1:0] result_add2;
  logic [2:0]        dest_add2;
  logic              ready_add2;
  logic              finished_add1;
  logic              finished_add2;
  logic [3:0]        qi_cdb;
  logic [DATA_W-1:0] qi_cdb_data;
  logic              r_enable_add1;
  logic              r_enable_add2;
  logic [2:0]        r_target_add1;
  logic [2:0]        r_target_add2;
  logic              timeout_err;

  modport slave (
    input  valid_add1, result_add1, dest_add1,
    input  valid_add2, result_add2, dest_add2,
    input  finished_add1, finished_add2,
    output ready_add1, ready_add2,
    output qi_cdb, qi_cdb_data,
    output r_enable_add1, r_enable_add2, r_target_add1, r_target_add2,
    output timeout_err
  );

  modport master (
    output valid_add1, result_add1, dest_add1,
    output valid_add2, result_add2, dest_add2,
    output finished_add1, finished_add2,
    input  ready_add1, ready_add2,
    input  qi_cdb, qi_cdb_data,
    input  r_enable_add1, r_enable_add2, r_target_add1, r_target_add2,
    input  timeout_err
  );
endinterface

// File: rtl/cdb_broadcaster.sv
// CDB transmit side: one holding slot per adder, round-robin grant, one-cycle
// broadcast, then wait for the register table acknowledge (or give up on timeout).
module cdb_broadcaster #(
  parameter int unsigned       DATA_W      = 16,
  parameter logic [3:0]        TAG_NONE    = 4'd0,
  parameter logic [3:0]        TAG_ADD1    = 4'd1,
  parameter logic [3:0]        TAG_ADD2    = 4'd2,
  parameter logic [DATA_W-1:0] IDLE_DATA   = 16'hFFF0,
  parameter int unsigned       ACK_TIMEOUT = 8,
  parameter int unsigned       CNT_W       = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  cdb_broadcaster_if.slave     cdb
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BCAST = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  state_e            state_q, state_d;
  logic              sel_q, sel_d;
  logic              last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        qi_q, qi_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              ren1_q, ren1_d, ren2_q, ren2_d;
  logic [2:0]        rt1_q, rt1_d, rt2_q, rt2_d;
  logic              terr_q, terr_d;
  logic              slot_v1_q, slot_v2_q;
  logic [DATA_W-1:0] slot_data1_q, slot_data2_q;
  logic [2:0]        slot_dest1_q, slot_dest2_q;
  logic              grant_s, fin_sel_s, free1_s, free2_s;

  // Source select: 0 = ADD1, 1 = ADD2; with both pending, the one not served last wins.
  assign grant_s   = (slot_v1_q && slot_v2_q) ? ~last_q : slot_v2_q;
  assign fin_sel_s = sel_q ? cdb.finished_add2 : cdb.finished_add1;

  // Next-state and next-output logic; outputs are computed for the state being entered.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    qi_d    = TAG_NONE;
    data_d  = IDLE_DATA;
    ren1_d  = 1'b0;
    ren2_d  = 1'b0;
    rt1_d   = rt1_q;
    rt2_d   = rt2_q;
    terr_d  = terr_q;
    free1_s = 1'b0;
    free2_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (slot_v1_q || slot_v2_q) begin
          sel_d   = grant_s;
          state_d = ST_BCAST;
          if (grant_s) begin
            qi_d   = TAG_ADD2;
            data_d = slot_data2_q;
            ren2_d = 1'b1;
            rt2_d  = slot_dest2_q;
          end else begin
            qi_d   = TAG_ADD1;
            data_d = slot_data1_q;
            ren1_d = 1'b1;
            rt1_d  = slot_dest1_q;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BCAST: begin
        state_d = ST_WAIT;
        cnt_d   = {CNT_W{1'b0}};
      end
      ST_WAIT: begin
        if (fin_sel_s || (cnt_q == CNT_LAST)) begin
          if (!fin_sel_s) begin
            terr_d = 1'b1;
          end else begin
            terr_d = terr_q;
          end
          free1_s = ~sel_q;
          free2_s = sel_q;
          last_d  = sel_q;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state and registered bus outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      sel_q   <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= {CNT_W{1'b0}};
      qi_q    <= TAG_NONE;
      data_q  <= IDLE_DATA;
      ren1_q  <= 1'b0;
      ren2_q  <= 1'b0;
      rt1_q   <= 3'd0;
      rt2_q   <= 3'd0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      qi_q    <= qi_d;
      data_q  <= data_d;
      ren1_q  <= ren1_d;
      ren2_q  <= ren2_d;
      rt1_q   <= rt1_d;
      rt2_q   <= rt2_d;
      terr_q  <= terr_d;
    end
  end

  // Holding slots: capture on Valid&Ready, release only when the broadcast leaves WAIT.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      slot_v1_q    <= 1'b0;
      slot_v2_q    <= 1'b0;
      slot_data1_q <= {DATA_W{1'b0}};
      slot_data2_q <= {DATA_W{1'b0}};
      slot_dest1_q <= 3'd0;
      slot_dest2_q <= 3'd0;
    end else begin
      if (free1_s) begin
        slot_v1_q <= 1'b0;
      end else if (cdb.valid_add1 && !slot_v1_q) begin
        slot_v1_q    <= 1'b1;
        slot_data1_q <= cdb.result_add1;
        slot_dest1_q <= cdb.dest_add1;
      end
      if (free2_s) begin
        slot_v2_q <= 1'b0;
      end else if (cdb.valid_add2 && !slot_v2_q) begin
        slot_v2_q    <= 1'b1;
        slot_data2_q <= cdb.result_add2;
        slot_dest2_q <= cdb.dest_add2;
      end
    end
  end

  assign cdb.ready_add1    = ~slot_v1_q;
  assign cdb.ready_add2    = ~slot_v2_q;
  assign cdb.qi_cdb        = qi_q;
  assign cdb.qi_cdb_data   = data_q;
  assign cdb.r_enable_add1 = ren1_q;
  assign cdb.r_enable_add2 = ren2_q;
  assign cdb.r_target_add1 = rt1_q;
  assign cdb.r_target_add2 = rt2_q;
  assign cdb.timeout_err   = terr_q;

endmodule
